multicycle_adder: RTL and testbench



---
 rtl/multicycle_adder_if.sv | 36 +++
 rtl/multicycle_adder.sv | 123 ++++++++++++
 tb/tb_multicycle_adder.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/multicycle_adder_if.sv
// Operand/result bundle for multicycle_adder; abort exists only with MULTICYCLE_ADDER_ABORT_EN.
// master drives requests and operands; slave returns status and registered results.
interface multicycle_adder_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             subtract;
  logic             carryin;
`ifdef MULTICYCLE_ADDER_ABORT_EN
  logic             abort;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carryout;
  logic             overflow;
  logic             zero;

  modport master (
`ifdef MULTICYCLE_ADDER_ABORT_EN
    output abort,
`endif
    output start, a, b, subtract, carryin,
    input  busy, done, sum, carryout, overflow, zero
  );

  modport slave (
`ifdef MULTICYCLE_ADDER_ABORT_EN
    input  abort,
`endif
    input  start, a, b, subtract, carryin,
    output busy, done, sum, carryout, overflow, zero
  );
endinterface

// File: rtl/multicycle_adder.sv
// Chunked add/subtract, CHUNK bits per clock; result and done pulse N=WIDTH/CHUNK edges after start.
// start is taken only in IDLE/DONE (no queueing); MULTICYCLE_ADDER_ABORT_EN adds an abort input.
module multicycle_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic              clk,
  input  logic              reset,
  multicycle_adder_if.slave bus
);
  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("multicycle_adder: CHUNK must divide WIDTH");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic             finish;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] partial;
  logic [WIDTH-1:0] partial_nxt;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic [CHUNK:0]   chunk_res;
  logic             ovf_nxt;

  logic [WIDTH-1:0] sum_q;
  logic             carryout_q;
  logic             overflow_q;
  logic             zero_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
`ifdef MULTICYCLE_ADDER_ABORT_EN
        // Abort beats completion on the last chunk.
        if (bus.abort) begin
          state_nxt = IDLE;
        end else
`endif
        if (idx == LAST) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands shift right each step so the active chunk is always at bit 0;
  // the partial result fills in from the top and is fully aligned after N steps.
  always_comb begin
    chunk_res   = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
    partial_nxt = (partial >> CHUNK) | (WIDTH'(chunk_res[CHUNK-1:0]) << (WIDTH - CHUNK));
    // Carry into the MSB is recovered as a^b^sum at that bit.
    ovf_nxt     = a_sh[CHUNK-1] ^ b_sh[CHUNK-1] ^ chunk_res[CHUNK-1] ^ chunk_res[CHUNK];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh       <= '0;
      b_sh       <= '0;
      partial    <= '0;
      carry      <= 1'b0;
      idx        <= '0;
      sum_q      <= '0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else if (accept) begin
      a_sh    <= bus.a;
      b_sh    <= bus.subtract ? ~bus.b : bus.b;
      carry   <= bus.subtract | bus.carryin;
      partial <= '0;
      idx     <= '0;
    end else if (state == RUN) begin
      a_sh    <= a_sh >> CHUNK;
      b_sh    <= b_sh >> CHUNK;
      carry   <= chunk_res[CHUNK];
      partial <= partial_nxt;
      idx     <= idx + IDX_W'(1);
      if (finish) begin
        sum_q      <= partial_nxt;
        carryout_q <= chunk_res[CHUNK];
        overflow_q <= ovf_nxt;
        zero_q     <= (partial_nxt == '0);
      end
    end
  end

  assign bus.busy     = (state == RUN);
  assign bus.done     = (state == DONE);
  assign bus.sum      = sum_q;
  assign bus.carryout = carryout_q;
  assign bus.overflow = overflow_q;
  assign bus.zero     = zero_q;
endmodule

// File: tb/tb_multicycle_adder.sv
// Four builds (8/4, 8/2, 16/1, 16/16) share one stimulus stream and are compared every
// cycle against an arithmetic reference with an N-edge completion schedule.
module tb_multicycle_adder;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        subtract;
  logic        carryin;
`ifdef MULTICYCLE_ADDER_ABORT_EN
  logic        abort;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multicycle_adder_if #(.WIDTH(8))  if0 ();
  multicycle_adder_if #(.WIDTH(8))  if1 ();
  multicycle_adder_if #(.WIDTH(16)) if2 ();
  multicycle_adder_if #(.WIDTH(16)) if3 ();

  assign if0.start = start;  assign if0.a = a[7:0];  assign if0.b = b[7:0];
  assign if0.subtract = subtract;  assign if0.carryin = carryin;
  assign if1.start = start;  assign if1.a = a[7:0];  assign if1.b = b[7:0];
  assign if1.subtract = subtract;  assign if1.carryin = carryin;
  assign if2.start = start;  assign if2.a = a;  assign if2.b = b;
  assign if2.subtract = subtract;  assign if2.carryin = carryin;
  assign if3.start = start;  assign if3.a = a;  assign if3.b = b;
  assign if3.subtract = subtract;  assign if3.carryin = carryin;
`ifdef MULTICYCLE_ADDER_ABORT_EN
  assign if0.abort = abort;  assign if1.abort = abort;
  assign if2.abort = abort;  assign if3.abort = abort;
`endif

  multicycle_adder #(.WIDTH(8),  .CHUNK(4))  dut0 (.clk(clk), .reset(reset), .bus(if0));
  multicycle_adder #(.WIDTH(8),  .CHUNK(2))  dut1 (.clk(clk), .reset(reset), .bus(if1));
  multicycle_adder #(.WIDTH(16), .CHUNK(1))  dut2 (.clk(clk), .reset(reset), .bus(if2));
  multicycle_adder #(.WIDTH(16), .CHUNK(16)) dut3 (.clk(clk), .reset(reset), .bus(if3));

  // Observed status per build: {busy, done, carryout, overflow, zero, sum[15:0]}
  logic [20:0] obs [4];
  assign obs[0] = {if0.busy, if0.done, if0.carryout, if0.overflow, if0.zero, 8'h00, if0.sum};
  assign obs[1] = {if1.busy, if1.done, if1.carryout, if1.overflow, if1.zero, 8'h00, if1.sum};
  assign obs[2] = {if2.busy, if2.done, if2.carryout, if2.overflow, if2.zero, if2.sum};
  assign obs[3] = {if3.busy, if3.done, if3.carryout, if3.overflow, if3.zero, if3.sum};

  int          w_of [4] = '{8, 8, 16, 16};
  int          n_of [4] = '{2, 4, 16, 1};
  logic        m_busy [4];
  logic        m_done [4];
  int          m_left [4];
  logic [18:0] m_res  [4];
  logic [18:0] m_out  [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Returns {carryout, overflow, zero, sum} for a w-bit two's-complement add/subtract.
  function automatic logic [18:0] ref_op(input int w, input logic [15:0] x, input logic [15:0] y,
                                         input logic sub, input logic cin);
    logic [16:0] mask, xa, yb, full, s;
    logic        co, ov, z;
    mask = (17'd1 << w) - 17'd1;
    xa   = {1'b0, x} & mask;
    yb   = {1'b0, (sub ? ~y : y)} & mask;
    full = xa + yb + {16'd0, (sub | cin)};
    s    = full & mask;
    co   = full[w];
    ov   = (xa[w-1] == yb[w-1]) && (s[w-1] != xa[w-1]);
    z    = (s == 17'd0);
    return {co, ov, z, s[15:0]};
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 4; k++) begin
      if (reset) begin
        m_busy[k] = 1'b0;  m_done[k] = 1'b0;  m_left[k] = 0;  m_out[k] = '0;
      end else if (m_busy[k]) begin
        m_done[k] = 1'b0;
`ifdef MULTICYCLE_ADDER_ABORT_EN
        if (abort) begin
          m_busy[k] = 1'b0;
        end else
`endif
        begin
          m_left[k]--;
          if (m_left[k] == 0) begin
            m_busy[k] = 1'b0;  m_done[k] = 1'b1;  m_out[k] = m_res[k];
          end
        end
      end else begin
        m_done[k] = 1'b0;
        if (start) begin
          m_busy[k] = 1'b1;
          m_left[k] = n_of[k];
          m_res[k]  = ref_op(w_of[k], a, b, subtract, carryin);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int k = 0; k < 4; k++)
      check($sformatf("dut%0d_status", k), {11'd0, obs[k]}, {11'd0, m_busy[k], m_done[k], m_out[k]});
  endtask

  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic sub, input logic cin);
    a = x;  b = y;  subtract = sub;  carryin = cin;  start = 1'b1;
    step();
    start = 1'b0;
    repeat (17) step();
  endtask

  initial begin
    reset = 1'b1;  start = 1'b0;  a = '0;  b = '0;  subtract = 1'b0;  carryin = 1'b0;
`ifdef MULTICYCLE_ADDER_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) step();
    reset = 1'b0;
    step();

    run_op(16'h007F, 16'h0001, 1'b0, 1'b0);
    check("add_7f_01_w8", {13'd0, obs[0][18:0]}, {13'd0, 3'b010, 16'h0080});
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
    check("add_ff_01_w8", {13'd0, obs[0][18:0]}, {13'd0, 3'b101, 16'h0000});
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b1);
    check("add_ff_01_cin_w8", {13'd0, obs[0][18:0]}, {13'd0, 3'b100, 16'h0001});
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1);
    check("sub_05_07_w8c2", {13'd0, obs[1][18:0]}, {13'd0, 3'b000, 16'h00FE});
    run_op(16'h0080, 16'h0001, 1'b1, 1'b0);
    check("sub_80_01_w8c2", {13'd0, obs[1][18:0]}, {13'd0, 3'b110, 16'h007F});

    // Start held high with fresh operands every cycle.
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);  b = 16'($urandom);
      subtract = 1'($urandom);  carryin = 1'($urandom);  start = 1'b1;
      step();
    end
    start = 1'b0;
    repeat (17) step();

    // Reset on the second RUN cycle discards the operation.
    a = 16'h1234;  b = 16'h0F0F;  subtract = 1'b0;  carryin = 1'b0;  start = 1'b1;
    step();
    start = 1'b0;
    step();
    reset = 1'b1;
    step();
    check("reset_run_w8c4", {11'd0, obs[0]}, 32'd0);
    reset = 1'b0;
    repeat (17) step();
    run_op(16'hABCD, 16'h5432, 1'b0, 1'b1);

`ifdef MULTICYCLE_ADDER_ABORT_EN
    run_op(16'h0011, 16'h0022, 1'b0, 1'b0);
    a = 16'h00F0;  b = 16'h0001;  start = 1'b1;
    step();
    start = 1'b0;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_last_w8c4", {13'd0, obs[0][18:0]}, {13'd0, 3'b000, 16'h0033});
    repeat (17) step();
`endif

    for (int i = 0; i < 300; i++) begin
      a = 16'($urandom);  b = 16'($urandom);
      subtract = 1'($urandom);  carryin = 1'($urandom);
      start = ($urandom_range(0, 3) != 0);
`ifdef MULTICYCLE_ADDER_ABORT_EN
      abort = ($urandom_range(0, 15) == 0);
`endif
      step();
    end
    start = 1'b0;
`ifdef MULTICYCLE_ADDER_ABORT_EN
    abort = 1'b0;
`endif
    repeat (17) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
